shift_sweep_ctrl: RTL and testbench
===================================

SHIFT_SWEEP_CTRL -- requirements
Module: shift_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning the data width; it SHALL be >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; asynchronous, active-high.
REQ-004 The block SHALL have port in_bits, input, width bits, the word to be swept.
REQ-005 The block SHALL have port in_maxShift, input, clog2(width) bits, the last shift amount of the sweep.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the upstream offers a word.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port out_bits, output, width bits, the held word, which drives the shifter's iBits.
REQ-009 The block SHALL have port out_shift, output, clog2(width) bits, the current shift amount, which drives the shifter's shift.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning out_bits and out_shift are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the downstream consumer of the shifter's oBits accepts this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit, high while in state SWEEP.

Function
REQ-013 The block SHALL implement two states: IDLE and SWEEP.
REQ-014 An input handshake SHALL occur when in_valid && in_ready; an output handshake SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 in IDLE, and 1 in SWEEP only in the cycle where out_ready=1 and cnt==max; it SHALL be 0 otherwise.
REQ-016 On an input handshake, the block SHALL register in_bits into held, register min(in_maxShift, width-1) into max, set cnt=0, and enter SWEEP on the next cycle.
REQ-017 In SWEEP, out_valid SHALL be 1, out_bits SHALL equal held, and out_shift SHALL equal cnt; all are register outputs with no combinational path from in_*.
REQ-018 On an output handshake with cnt<max, cnt SHALL increment by 1.
REQ-019 On an output handshake with cnt==max and no input handshake, the block SHALL go to IDLE.
REQ-020 On an output handshake with cnt==max coinciding with an input handshake, the block SHALL load the new word, set cnt=0, and stay in SWEEP, giving back-to-back sweeps with no bubble.
REQ-021 While out_valid=1 and out_ready=0, out_bits, out_shift and cnt SHALL hold stable.
REQ-022 Latency: the first output SHALL be valid 1 cycle after the input handshake; each word SHALL produce exactly max+1 output handshakes, with shift values 0,1,...,max in order.
REQ-023 When max==0, the block SHALL produce a single output with shift 0.
REQ-024 In IDLE, out_valid SHALL be 0, and out_bits/out_shift SHALL hold their last values.

Reset
REQ-025 While rst=1, the block SHALL force state=IDLE, cnt=0, max=0, held=0, out_valid=0, busy=0, out_bits=0 and out_shift=0, independent of clk.
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep; no output SHALL be emitted for that word after rst is released.
REQ-027 After reset release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 With macro SHIFT_SWEEP_LAST_EN defined, the block SHALL add output port out_last, 1 bit, equal to (state==SWEEP && cnt==max), with reset value 0.
REQ-029 Without SHIFT_SWEEP_LAST_EN, port out_last SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover this scenario: width=8, send in_bits=0x81 with in_maxShift=3 and out_ready=1 constant -> out_shift=0,1,2,3 on 4 consecutive cycles starting 1 cycle after accept, out_bits=0x81 throughout, then out_valid=0.
REQ-031 The bench SHALL cover this scenario: same stimulus with out_ready=0 for 3 cycles at cnt=1 -> out_shift stays 1 and out_bits stays 0x81, then the sweep resumes at 2 with no skipped or repeated values.
REQ-032 The bench SHALL cover this scenario: in_valid held high with words 0xAA (max 1) then 0x55 (max 2) -> output sequence (0xAA,0),(0xAA,1),(0x55,0),(0x55,1),(0x55,2) with no idle cycle between words.
REQ-033 The bench SHALL cover this scenario: in_maxShift=0 with in_bits=0xFF -> exactly one output (0xFF,0); with SHIFT_SWEEP_LAST_EN defined, out_last=1 on that output.
REQ-034 The bench SHALL cover this scenario: rst pulsed asynchronously (between clk edges) at cnt=2 of a max-7 sweep -> out_valid=0 immediately, and after release in_ready=1 with no further outputs for that word.
REQ-035 The bench SHALL cover this scenario: width=6, in_maxShift=7 -> max clamped to 5, giving 6 outputs with shift 0..5.

Source files
------------

// File: rtl/shift_sweep_ctrl.sv
// Sweeps a held word through shift amounts 0..max, one per output handshake.
// Ports: clk, rst (async high); in_bits/in_maxShift/in_valid/in_ready upstream;
// out_bits/out_shift/out_valid/out_ready downstream; busy = sweeping.
// Option: define SHIFT_SWEEP_LAST_EN to add out_last (final shift of a sweep).
module shift_sweep_ctrl #(
  parameter  int width = 8,
  localparam int sw    = $clog2(width)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_bits,
  input  logic [sw-1:0]    in_maxShift,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_bits,
  output logic [sw-1:0]    out_shift,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_SWEEP_LAST_EN
  output logic             out_last,
`endif
  output logic             busy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [sw-1:0] top = sw'(width - 1);

  state_t           state;
  state_t           state_n;
  logic [width-1:0] held;
  logic [sw-1:0]    cnt;
  logic [sw-1:0]    max_q;
  logic [sw-1:0]    clamped;
  logic             at_max;
  logic             load;
  logic             step;

  // in_maxShift can exceed width-1 when width is not a power of two
  assign clamped = (in_maxShift > top) ? top : in_maxShift;
  assign at_max  = (cnt == max_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_n = SWEEP;
        end
      end
      SWEEP: begin
        if (out_ready) begin
          if (at_max) begin
            // last shift leaves: take the next word with no bubble
            in_ready = 1'b1;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held  <= '0;
      max_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      held  <= in_bits;
      max_q <= clamped;
      cnt   <= '0;
    end else if (step) begin
      cnt <= cnt + sw'(1);
    end
  end

  // held/cnt keep their values in IDLE, so outputs hold their last word
  assign out_bits  = held;
  assign out_shift = cnt;
  assign out_valid = (state == SWEEP);
  assign busy      = (state == SWEEP);

`ifdef SHIFT_SWEEP_LAST_EN
  assign out_last = (state == SWEEP) && at_max;
`endif

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Directed bench for shift_sweep_ctrl at width 8 and width 6.
// Expected outputs are queued at stimulus time and popped on each handshake.
module tb_shift_sweep_ctrl;

  typedef struct {
    logic [7:0] b;
    logic [2:0] s;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;

  logic [7:0] ib8;
  logic [2:0] im8;
  logic       iv8;
  logic       ir8;
  logic [7:0] ob8;
  logic [2:0] os8;
  logic       ov8;
  logic       or8;
  logic       bz8;
  logic       ol8;

  logic [5:0] ib6;
  logic [2:0] im6;
  logic       iv6;
  logic       ir6;
  logic [5:0] ob6;
  logic [2:0] os6;
  logic       ov6;
  logic       or6;
  logic       bz6;
  logic       ol6;

  exp_t q8[$];
  exp_t q6[$];
  exp_t e;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_sweep_ctrl #(.width(8)) u8 (
    .clk(clk),
    .rst(rst),
    .in_bits(ib8),
    .in_maxShift(im8),
    .in_valid(iv8),
    .in_ready(ir8),
    .out_bits(ob8),
    .out_shift(os8),
    .out_valid(ov8),
    .out_ready(or8),
`ifdef SHIFT_SWEEP_LAST_EN
    .out_last(ol8),
`endif
    .busy(bz8)
  );

  shift_sweep_ctrl #(.width(6)) u6 (
    .clk(clk),
    .rst(rst),
    .in_bits(ib6),
    .in_maxShift(im6),
    .in_valid(iv6),
    .in_ready(ir6),
    .out_bits(ob6),
    .out_shift(os6),
    .out_valid(ov6),
    .out_ready(or6),
`ifdef SHIFT_SWEEP_LAST_EN
    .out_last(ol6),
`endif
    .busy(bz6)
  );

`ifndef SHIFT_SWEEP_LAST_EN
  assign ol8 = 1'b0;
  assign ol6 = 1'b0;
`endif

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, x);
    end
  endtask

  task automatic push(input int w, input logic [7:0] b,
                      input int m);
    int mx;
    exp_t t;
    mx = (m > w - 1) ? w - 1 : m;
    for (int s = 0; s <= mx; s++) begin
      t.b = b;
      t.s = 3'(s);
      t.l = (s == mx);
      if (w == 8) q8.push_back(t);
      else        q6.push_back(t);
    end
  endtask

  // one clock: score handshakes at negedge, return 1 after posedge
  task automatic tick();
    @(negedge clk);
    if (ov8 && or8) begin
      n_cmp++;
      assert (q8.size() != 0) else begin
        n_bad++;
        $error("FAIL extra8 observed=%0h/%0h expected=none", ob8, os8);
      end
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("bits8", 32'(ob8), 32'(e.b));
        chk("shift8", 32'(os8), 32'(e.s));
`ifdef SHIFT_SWEEP_LAST_EN
        chk("last8", 32'(ol8), 32'(e.l));
`endif
      end
    end
    if (ov6 && or6) begin
      n_cmp++;
      assert (q6.size() != 0) else begin
        n_bad++;
        $error("FAIL extra6 observed=%0h/%0h expected=none", ob6, os6);
      end
      if (q6.size() != 0) begin
        e = q6.pop_front();
        chk("bits6", 32'(ob6), 32'(e.b));
        chk("shift6", 32'(os6), 32'(e.s));
`ifdef SHIFT_SWEEP_LAST_EN
        chk("last6", 32'(ol6), 32'(e.l));
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ib8 = '0; im8 = '0; iv8 = 1'b0; or8 = 1'b1;
    ib6 = '0; im6 = '0; iv6 = 1'b0; or6 = 1'b1;
    #2;
    chk("rst_valid", 32'(ov8), 0);
    chk("rst_busy", 32'(bz8), 0);
    chk("rst_bits", 32'(ob8), 0);
    chk("rst_shift", 32'(os8), 0);
    chk("rst_last", 32'(ol8), 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rel_ready", 32'(ir8), 1);
    chk("rel_valid", 32'(ov8), 0);

    // plain sweep 0x81, max 3
    ib8 = 8'h81; im8 = 3'd3; iv8 = 1'b1;
    push(8, 8'h81, 3);
    tick();
    iv8 = 1'b0;
    chk("s1_first_valid", 32'(ov8), 1);
    chk("s1_first_shift", 32'(os8), 0);
    chk("s1_busy", 32'(bz8), 1);
    chk("s1_ready_lo", 32'(ir8), 0);
    tick(); tick(); tick();
    chk("s1_shift3", 32'(os8), 3);
    chk("s1_ready_last", 32'(ir8), 1);
    tick();
    chk("s1_done", 32'(ov8), 0);
    chk("s1_busy_lo", 32'(bz8), 0);
    chk("s1_hold_bits", 32'(ob8), 32'h81);
    chk("s1_q", q8.size(), 0);

    // stall at cnt 1 for 3 cycles
    iv8 = 1'b1;
    push(8, 8'h81, 3);
    tick();
    iv8 = 1'b0;
    tick();
    or8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_stall_shift", 32'(os8), 1);
      chk("s2_stall_bits", 32'(ob8), 32'h81);
      chk("s2_stall_valid", 32'(ov8), 1);
      chk("s2_stall_ready", 32'(ir8), 0);
    end
    or8 = 1'b1;
    tick(); tick(); tick();
    chk("s2_done", 32'(ov8), 0);
    chk("s2_q", q8.size(), 0);

    // back to back 0xAA/1 then 0x55/2
    ib8 = 8'hAA; im8 = 3'd1; iv8 = 1'b1;
    push(8, 8'hAA, 1);
    tick();
    ib8 = 8'h55; im8 = 3'd2;
    push(8, 8'h55, 2);
    tick();
    chk("s3_ready", 32'(ir8), 1);
    tick();
    iv8 = 1'b0;
    chk("s3_nobubble", 32'(ov8), 1);
    chk("s3_new_bits", 32'(ob8), 32'h55);
    chk("s3_new_shift", 32'(os8), 0);
    tick(); tick(); tick();
    chk("s3_done", 32'(ov8), 0);
    chk("s3_q", q8.size(), 0);

    // max 0: a single output
    ib8 = 8'hFF; im8 = 3'd0; iv8 = 1'b1;
    push(8, 8'hFF, 0);
    tick();
    iv8 = 1'b0;
    chk("s4_valid", 32'(ov8), 1);
    chk("s4_ready", 32'(ir8), 1);
`ifdef SHIFT_SWEEP_LAST_EN
    chk("s4_last", 32'(ol8), 1);
`endif
    tick();
    chk("s4_done", 32'(ov8), 0);
    chk("s4_q", q8.size(), 0);

    // async reset at cnt 2 of a max-7 sweep
    ib8 = 8'h3C; im8 = 3'd7; iv8 = 1'b1;
    push(8, 8'h3C, 1);
    tick();
    iv8 = 1'b0;
    tick(); tick();
    chk("s5_cnt2", 32'(os8), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(ov8), 0);
    chk("s5_rst_busy", 32'(bz8), 0);
    chk("s5_rst_shift", 32'(os8), 0);
    chk("s5_rst_bits", 32'(ob8), 0);
    tick();
    rst = 1'b0;
    chk("s5_rel_ready", 32'(ir8), 1);
    chk("s5_rel_valid", 32'(ov8), 0);
    for (int i = 0; i < 8; i++) tick();
    chk("s5_q", q8.size(), 0);

    // width 6, request 7 -> clamped to 5
    ib6 = 6'h2A; im6 = 3'd7; iv6 = 1'b1;
    push(6, 8'h2A, 7);
    tick();
    iv6 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("s6_shift5", 32'(os6), 5);
    chk("s6_valid5", 32'(ov6), 1);
    tick();
    chk("s6_done", 32'(ov6), 0);
    chk("s6_q", q6.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
